// File: rtl/llpm_fork_pkg.sv
// Shared sizing helpers for LLPM buffered primitives: ceil-log2 and the
// derived occupancy-counter and pointer widths.
package llpm_fork_pkg;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    // Read/write pointer width; a single-entry lane still gets one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fork_lane_fifo.sv
// Single output lane of buffered_fork: a Depth-entry register FIFO with
// registered-only read data (no fall-through) and an explicit occupancy count.
module fork_lane_fifo
    import llpm_fork_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 2,
    localparam int CW = count_width(Depth)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_width(Depth);
    localparam logic [PW-1:0] LastIdx = PW'(Depth - 1);
    localparam logic [CW-1:0] DepthCount = CW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DepthCount);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Depth need not be a power of two, so wrap explicitly at the last index.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is reset deliberately so rdata never carries X out of the
    // read mux, even while the lane is empty; this costs a reset net per bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/buffered_fork.sv
// One-to-NumOutputs stream fork with a Depth-entry FIFO per consumer lane.
// Optional FORK_DEST_MASK_EN adds din_mask to push only into selected lanes.
module buffered_fork
    import llpm_fork_pkg::*;
#(
    parameter int Width      = 8,
    parameter int NumOutputs = 4,
    parameter int Depth      = 2,
    localparam int CW = count_width(Depth)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [Width-1:0]           din,
    input  logic                       din_valid,
    output logic                       din_bp,
`ifdef FORK_DEST_MASK_EN
    input  logic [NumOutputs-1:0]      din_mask,
`endif
    output logic [NumOutputs*Width-1:0] dout,
    output logic [NumOutputs-1:0]      dout_valid,
    input  logic [NumOutputs-1:0]      dout_bp,
    output logic [NumOutputs*CW-1:0]   dout_count
);

    logic [NumOutputs-1:0] sel;
    logic [NumOutputs-1:0] full;
    logic                  accept;

`ifdef FORK_DEST_MASK_EN
    assign sel = din_mask;
`else
    assign sel = '1;
`endif

    // Built from registered lane counts only: a same-cycle pop never frees
    // room for a push, which keeps dout_bp off the din_bp timing path.
    assign din_bp = |(full & sel);
    assign accept = din_valid & ~din_bp;

    for (genvar i = 0; i < NumOutputs; i++) begin : g_lane
        logic             lane_empty;
        logic [Width-1:0] lane_data;
        logic [CW-1:0]    lane_count;

        fork_lane_fifo #(
            .Width (Width),
            .Depth (Depth)
        ) u_fifo (
            .clk    (clk),
            .resetn (resetn),
            .push   (accept & sel[i]),
            .pop    (~lane_empty & ~dout_bp[i]),
            .wdata  (din),
            .rdata  (lane_data),
            .count  (lane_count),
            .full   (full[i]),
            .empty  (lane_empty)
        );

        assign dout[i*Width +: Width]    = lane_data;
        assign dout_count[i*CW +: CW]    = lane_count;
        assign dout_valid[i]             = ~lane_empty;
    end

endmodule

// File: tb/tb_buffered_fork.sv
// Self-checking bench for buffered_fork: Depth=2 and Depth=3 instances share
// stimulus and are compared against per-lane queue models.
module tb_buffered_fork;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] bp;
        logic       exp_bp;
        logic [3:0] exp_valid;
        logic [1:0] exp_cnt2;
        logic [7:0] exp_d2;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [7:0]  din;
    logic        din_valid;
    logic [3:0]  dout_bp;
`ifdef FORK_DEST_MASK_EN
    logic [3:0]  din_mask;
`endif
    logic [31:0] dout0, dout1;
    logic [3:0]  dv0, dv1;
    logic [7:0]  cnt0, cnt1;
    logic        bp0, bp1;

    buffered_fork #(.Width(8), .NumOutputs(4), .Depth(2)) u_dut2 (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .din_bp     (bp0),
`ifdef FORK_DEST_MASK_EN
        .din_mask   (din_mask),
`endif
        .dout       (dout0),
        .dout_valid (dv0),
        .dout_bp    (dout_bp),
        .dout_count (cnt0)
    );

    buffered_fork #(.Width(8), .NumOutputs(4), .Depth(3)) u_dut3 (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .din_bp     (bp1),
`ifdef FORK_DEST_MASK_EN
        .din_mask   (din_mask),
`endif
        .dout       (dout1),
        .dout_valid (dv1),
        .dout_bp    (dout_bp),
        .dout_count (cnt1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mq [2][4][$];
    logic       acc [2];
    logic [3:0] sel_q;
    logic [3:0] bp_q;
    logic [7:0] d_q;
    vec_t       tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int u);
        return (u == 0) ? 2 : 3;
    endfunction

    function automatic logic [7:0] get_dout(input int u, input int i);
        return (u == 0) ? dout0[i*8 +: 8] : dout1[i*8 +: 8];
    endfunction

    function automatic logic [1:0] get_cnt(input int u, input int i);
        return (u == 0) ? cnt0[i*2 +: 2] : cnt1[i*2 +: 2];
    endfunction

    // Drive one cycle's inputs, then compare every output to the queue model.
    task automatic apply(input logic v, input logic [7:0] d, input logic [3:0] bp, input logic [3:0] m);
        logic [3:0] sel;
        logic       ebp;
        logic [3:0] dv;
        int         sz;
        din_valid = v;
        din       = d;
        dout_bp   = bp;
`ifdef FORK_DEST_MASK_EN
        din_mask  = m;
        sel       = m;
`else
        sel       = 4'hF | m;
`endif
        #1;
        for (int u = 0; u < 2; u++) begin
            ebp = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (sel[i] && mq[u][i].size() == depth_of(u)) ebp = 1'b1;
            end
            check($sformatf("u%0d din_bp", u), 32'((u == 0) ? bp0 : bp1), 32'(ebp));
            dv = (u == 0) ? dv0 : dv1;
            for (int i = 0; i < 4; i++) begin
                sz = mq[u][i].size();
                check($sformatf("u%0d l%0d valid", u, i), 32'(dv[i]), 32'(sz != 0));
                check($sformatf("u%0d l%0d count", u, i), 32'(get_cnt(u, i)), 32'(sz));
                if (sz != 0) begin
                    check($sformatf("u%0d l%0d data", u, i), 32'(get_dout(u, i)), 32'(mq[u][i][0]));
                end
            end
            acc[u] = v & ~ebp;
        end
        sel_q = sel;
        bp_q  = bp;
        d_q   = d;
    endtask

    task automatic advance();
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) begin
                if (mq[u][i].size() != 0 && !bp_q[i]) void'(mq[u][i].pop_front());
                if (acc[u] && sel_q[i]) mq[u][i].push_back(d_q);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            apply(1'b0, 8'h00, 4'h0, 4'hF);
            advance();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;

        // Lane 2 stalls while the stream runs; columns are the Depth=2 instance.
        tbl[0] = '{1'b1, 8'h01, 4'b0100, 1'b0, 4'b0000, 2'd0, 8'h00};
        tbl[1] = '{1'b1, 8'h02, 4'b0100, 1'b0, 4'b1111, 2'd1, 8'h01};
        tbl[2] = '{1'b1, 8'h03, 4'b0100, 1'b1, 4'b1111, 2'd2, 8'h01};
        tbl[3] = '{1'b1, 8'h03, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'h01};
        tbl[4] = '{1'b1, 8'h03, 4'b0000, 1'b1, 4'b0100, 2'd2, 8'h01};
        tbl[5] = '{1'b1, 8'h03, 4'b0000, 1'b0, 4'b0100, 2'd1, 8'h02};
        tbl[6] = '{1'b1, 8'h04, 4'b0000, 1'b0, 4'b1111, 2'd1, 8'h03};
        tbl[7] = '{1'b0, 8'h00, 4'b0000, 1'b0, 4'b1111, 2'd1, 8'h04};
        tbl[8] = '{1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'h00};

        resetn    = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        dout_bp   = '0;
`ifdef FORK_DEST_MASK_EN
        din_mask  = 4'hF;
`endif
        repeat (2) @(negedge clk);
        check("reset dv0", 32'(dv0), 32'h0);
        check("reset dv1", 32'(dv1), 32'h0);
        check("reset cnt0", 32'(cnt0), 32'h0);
        check("reset cnt1", 32'(cnt1), 32'h0);
        check("reset bp0", 32'(bp0), 32'h0);
        check("reset dout0 zeroed", dout0, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            apply(tbl[k].v, tbl[k].d, tbl[k].bp, 4'hF);
            check($sformatf("tbl%0d din_bp", k), 32'(bp0), 32'(tbl[k].exp_bp));
            check($sformatf("tbl%0d valid", k), 32'(dv0), 32'(tbl[k].exp_valid));
            check($sformatf("tbl%0d count2", k), 32'(cnt0[5:4]), 32'(tbl[k].exp_cnt2));
            if (tbl[k].exp_valid[2]) begin
                check($sformatf("tbl%0d data2", k), 32'(dout0[23:16]), 32'(tbl[k].exp_d2));
            end
            advance();
        end
        drain(4);

        // Unstalled burst: lanes pass one token per cycle, no backpressure.
        for (int k = 0; k < 8; k++) begin
            apply(1'b1, 8'(k + 1), 4'h0, 4'hF);
            check($sformatf("burst%0d bp0", k), 32'(bp0), 32'h0);
            advance();
        end
        drain(4);

        // Ten tokens under random backpressure; the producer holds until the
        // Depth=3 instance accepts.
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 300) begin
            apply(1'b1, 8'(8'h10 + sent), 4'($urandom), 4'hF);
            if (acc[1]) sent++;
            advance();
            cyc++;
        end
        check("depth3 tokens accepted", 32'(sent), 32'd10);
        drain(12);
        check("depth3 drained", 32'(cnt1), 32'h0);

`ifdef FORK_DEST_MASK_EN
        apply(1'b1, 8'h33, 4'hF, 4'b0101);
        advance();
        apply(1'b0, 8'h00, 4'hF, 4'hF);
        check("mask0101 valid", 32'(dv0), 32'b0101);
        check("mask0101 lane0", 32'(dout0[7:0]), 32'h33);
        check("mask0101 lane2", 32'(dout0[23:16]), 32'h33);
        advance();
        apply(1'b1, 8'h44, 4'hF, 4'b0000);
        check("mask0000 bp", 32'(bp0), 32'h0);
        advance();
        apply(1'b0, 8'h00, 4'hF, 4'hF);
        check("mask0000 valid", 32'(dv0), 32'b0101);
        check("mask0000 counts", 32'(cnt0), 32'h11);
        advance();
        drain(4);
`endif

        for (int k = 0; k < 300; k++) begin
            apply(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom), 4'($urandom));
            advance();
        end

        // Asynchronous reset with lanes partly full.
        apply(1'b1, 8'h51, 4'hF, 4'hF);
        advance();
        apply(1'b1, 8'h52, 4'hF, 4'hF);
        advance();
        apply(1'b0, 8'h00, 4'hF, 4'hF);
        resetn = 1'b0;
        #1;
        check("async rst dv0", 32'(dv0), 32'h0);
        check("async rst dv1", 32'(dv1), 32'h0);
        check("async rst cnt0", 32'(cnt0), 32'h0);
        check("async rst cnt1", 32'(cnt1), 32'h0);
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) mq[u][i].delete();
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        apply(1'b1, 8'hAA, 4'h0, 4'hF);
        advance();
        apply(1'b0, 8'h00, 4'hF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post-rst l%0d d2", i), 32'(dout0[i*8 +: 8]), 32'hAA);
            check($sformatf("post-rst l%0d d3", i), 32'(dout1[i*8 +: 8]), 32'hAA);
        end
        advance();
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/buffered_fork.md
Name: buffered_fork

Overview:
- Parametrised successor to the single-register fork: one input stream is copied to NumOutputs consumers, each behind its own Depth-entry FIFO lane.
- A slow consumer no longer stalls the others until its own lane fills.
- Sits between a producer and several independently back-pressured consumers in generated LLPM datapaths.
- Valid/backpressure handshake (bp high = not ready), same as all LLPM channels.

Parameters:
- Width, 8, data bits per token.
- NumOutputs, 4, number of output channels (>=1).
- Depth, 2, entries per output lane FIFO (>=1; need not be a power of two).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- din  input  Width  input token.
- din_valid  input  1  input token present.
- din_bp  output  1  input backpressure; high = token not accepted this cycle.
- din_mask  input  NumOutputs  destination select; present only with FORK_DEST_MASK_EN.
- dout  output  NumOutputs*Width  lane i data at bits [i*Width +: Width].
- dout_valid  output  NumOutputs  lane i head valid.
- dout_bp  input  NumOutputs  consumer i backpressure.
- dout_count  output  NumOutputs*CW  lane i occupancy, where CW = clog2(Depth+1).

Behaviour:
- Reset (async assert, synchronous-to-clk deassert handled upstream):
  - All lane pointers and counts go to 0.
  - dout_valid = 0, dout_count = 0, din_bp = 0 when no lane is full (i.e. right after reset).
  - dout data is don't-care but must be driven with no X from the storage muxing; storage is zeroed.
- Selected set S:
  - All lanes by default.
  - din_mask lanes when FORK_DEST_MASK_EN is defined.
- din_bp = OR over i in S of full[i], where full[i] = (count[i] == Depth).
  - Computed from registered counts only.
  - A pop on lane i in the same cycle does NOT free space for a push; there is no comb path dout_bp -> din_bp.
  - din_bp is independent of din_valid.
- Accept condition: din_valid & ~din_bp.
  - On acceptance, din is written at wr_ptr[i] of every lane in S in the same edge.
  - Either all selected lanes are written or none are.
- Pop on lane i: dout_valid[i] & ~dout_bp[i]; rd_ptr[i] advances.
- dout_valid[i] = (count[i] != 0). dout[i] = mem[i][rd_ptr[i]], read directly from registers.
- Latency: a token accepted at edge N is visible on dout at cycle N+1. No fall-through.
- Simultaneous push and pop on the same non-full lane: count unchanged, both pointers advance.
- Pointers wrap from Depth-1 to 0. Counts saturate logically at Depth and can never exceed it.
- Throughput:
  - Depth = 1 limits each lane to one token every 2 cycles.
  - Depth >= 2 sustains 1 token/cycle when consumers never stall.
- Ordering: each lane delivers tokens in acceptance order. Lanes are mutually unordered.
- Reset asserted mid-operation: all buffered tokens are discarded immediately; no partial delivery resumes after release.

Optional Feature:
- Macro: FORK_DEST_MASK_EN.
- Defined:
  - Adds the din_mask port; an accepted token is pushed only into lanes with a mask bit set.
  - Backpressure considers only masked lanes.
  - An all-zero mask gives din_bp = 0; the token is consumed and dropped with no lane change.
- Undefined: no din_mask port; S = all lanes (plain broadcast).

Decomposition:
- Shared package llpm_fork_pkg: the count-width function clog2 and the CW derivation, reused by other LLPM buffered primitives.
- One natural sub-module: fork_lane_fifo (Width, Depth; push, pop, data in/out, count, full, empty), instantiated NumOutputs times with a generate loop.
- The top level holds only the S/backpressure logic and the output-bus packing.

Test Plan:
- Reset, then a burst of 8 tokens 0x01..0x08, all dout_bp = 0, NumOutputs = 4, Depth = 2 -> each lane outputs 0x01..0x08 in order, one per cycle, first at cycle N+1; din_bp never asserts.
- Hold dout_bp[2] = 1, others 0, stream continuously -> after 2 accepts lane 2 is full, din_bp = 1, dout_count[2] = 2; on release of dout_bp[2], lane 2 drains 0x01, 0x02, and din_bp drops one cycle after the first pop.
- Lane full with a pop and din_valid in the same cycle -> din_bp stays 1 that cycle, the push happens next cycle, no token lost or duplicated.
- Depth = 3, 10 tokens with random dout_bp on every lane -> each lane's sequence equals the input sequence; pointer wrap at index 2 is exercised; count never exceeds 3.
- Assert resetn low mid-burst with lanes partly full -> dout_valid = 0 and counts = 0 immediately (asynchronously); after release, new token 0xAA appears first on all lanes.
- FORK_DEST_MASK_EN: mask 4'b0101 with token 0x33 -> only lanes 0 and 2 receive it. Then mask 4'b0000 with token 0x44 -> din_bp = 0, all lanes unchanged.
